// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Four-digit multiplexed 7-segment scanner. It divides clk into
//                per-digit time slots and cycles the active-low anodes. New
//                data is double-buffered and committed only at frame
//                boundaries, so a frame never mixes old and new nibbles.
//                Leading-zero blanking is optional.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        blank_lz,
  output logic [15:0] digit_val,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shown;
  logic [15:0]   pend_data;
  logic          tick;
  logic          frame_end;
  logic [3:0]    nib;
  logic          blank;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == 2'd3);

  // Slot divider and digit index; idx steps once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer. The boundary commits the value that was pending before
  // this edge, and a load on the same edge becomes the next pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown     <= 16'h0000;
      pend_data <= 16'h0000;
      pending   <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        shown <= pend_data;
      end
      if (load) begin
        pend_data <= data;
        pending   <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Anode select and digit value, with leading-zero blanking on digits 3..1.
  always_comb begin
    an    = ~(4'b0001 << idx);
    nib   = shown[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd1:    blank = blank_lz && (shown[15:4]  == 12'h000);
      2'd2:    blank = blank_lz && (shown[15:8]  == 8'h00);
      2'd3:    blank = blank_lz && (shown[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    digit_val = blank ? 16'hFFFF : {12'h000, nib};
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan
//  Description : Self-checking bench for seg7_scan (DIV=4). It uses directed
//                scenarios plus randomized loads, blanking and resets. Each
//                one is compared against a reference model that works from
//                elapsed cycles and frame arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic        blank_lz;
  logic [15:0] digit_val;
  logic [3:0]  an;
  logic        pending;

  int n_checks;
  int n_errors;

  // Reference model state: edges since reset release, displayed and queued values.
  int          k;
  logic [15:0] m_shown;
  logic [15:0] m_pend;
  logic        m_pending;

  seg7_scan #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (data),
    .blank_lz  (blank_lz),
    .digit_val (digit_val),
    .an        (an),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, obs, exp);
    end
  endtask

  function automatic int cur_idx();
    return (k / DIV) % 4;
  endfunction

  function automatic logic [15:0] exp_dv(input logic bl);
    int          i;
    logic [15:0] upper;
    i     = cur_idx();
    upper = m_shown >> (4 * i);
    if (bl && i != 0 && upper == 16'h0000) return 16'hFFFF;
    return {12'h000, upper[3:0]};
  endfunction

  function automatic logic [15:0] exp_an();
    logic [3:0] a;
    a = 4'hF;
    a[cur_idx()] = 1'b0;
    return {12'h000, a};
  endfunction

  task automatic compare_all();
    check("an",        {12'h000, an},      exp_an());
    check("digit_val", digit_val,          exp_dv(blank_lz));
    check("pending",   {15'h0000, pending}, {15'h0000, m_pending});
  endtask

  task automatic model_reset();
    k         = 0;
    m_shown   = 16'h0000;
    m_pend    = 16'h0000;
    m_pending = 1'b0;
  endtask

  // One clock: apply inputs, advance the model on the rising edge, compare on the falling edge.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic bl);
    logic boundary;
    load     = ld;
    data     = d;
    blank_lz = bl;
    @(posedge clk);
    boundary = ((k % FRAME) == FRAME - 1);
    if (boundary && m_pending) m_shown = m_pend;
    if (ld) begin
      m_pend    = d;
      m_pending = 1'b1;
    end else if (boundary) begin
      m_pending = 1'b0;
    end
    k++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, bl);
  endtask

  // Assert reset mid-cycle; the outputs must clear without waiting for an edge.
  // Loads are held high across an edge while in reset and must be ignored.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_an",  {12'h000, an},       16'h000E);
    check("rst_dv",  digit_val,           16'h0000);
    check("rst_pnd", {15'h0000, pending}, 16'h0000);
    model_reset();
    load = 1'b1;
    data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_an",  {12'h000, an},       16'h000E);
    check("rst_hold_pnd", {15'h0000, pending}, 16'h0000);
    load  = 1'b0;
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] rd;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    data     = 16'h0000;
    blank_lz = 1'b0;
    model_reset();

    do_reset();

    // Idle scan after reset: anodes rotate, all digits show zero.
    idle(20, 1'b0);

    // Single load, committed at the next frame boundary.
    do_reset();
    idle(4, 1'b0);
    cycle(1'b1, 16'h12AF, 1'b0);
    idle(36, 1'b0);
    check("shown_12AF", m_shown, 16'h12AF);

    // Two loads in one frame: only the latest is displayed.
    while ((k % FRAME) != 2) idle(1, 1'b0);
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    idle(36, 1'b0);

    // Leading-zero blanking on 00A0, toggled without a boundary, then all-zero.
    cycle(1'b1, 16'h00A0, 1'b1);
    idle(32, 1'b1);
    idle(8, 1'b0);
    idle(8, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1);
    idle(36, 1'b1);

    // Load on the wrap cycle while another value is pending.
    while ((k % FRAME) != 3) idle(1, 1'b0);
    cycle(1'b1, 16'h3333, 1'b0);
    while ((k % FRAME) != FRAME - 1) idle(1, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0);
    check("wrap_first", m_shown, 16'h3333);
    idle(FRAME, 1'b0);
    check("wrap_second", m_shown, 16'h5555);
    idle(8, 1'b0);

    // Reset mid-frame with a value pending: the pending value is discarded.
    while ((k % FRAME) != 5) idle(1, 1'b0);
    cycle(1'b1, 16'h9876, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(40, 1'b0);

    // Randomized traffic, with data biased toward leading zeros.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rd = 16'($urandom);
        case ($urandom_range(0, 3))
          0: rd = rd & 16'h000F;
          1: rd = rd & 16'h00FF;
          2: rd = rd & 16'h0FFF;
          default: ;
        endcase
        cycle($urandom_range(0, 5) == 0, rd,
              ($urandom_range(0, 9) == 0) ? ~blank_lz : blank_lz);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 50000, refresh-tick divider: one digit slot lasts DIV clk cycles; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  write strobe; data is sampled on each rising edge where load=1.
REQ-005 data  input  16  four hex nibbles to display; data[3:0] is digit 0 (rightmost).
REQ-006 blank_lz  input  1  1 = suppress leading zeros on digits 3..1.
REQ-007 digit_val  output  16  value fed to the seg7 decoder input: 16'h000X for nibble X; 16'hFFFF for a blanked digit, which the decoder renders all-off.
REQ-008 an  output  4  digit anode select, active-low, exactly one bit low at all times.
REQ-009 pending  output  1  1 = a loaded value is waiting for the next frame boundary.

Function
REQ-010 Divider cnt SHALL count 0..DIV-1 and wrap to 0; tick=1 in the cycle where cnt==DIV-1.
REQ-011 Digit index idx (2 bits) SHALL advance by 1 modulo 4 on each tick; order 0,1,2,3,0.
REQ-012 Frame boundary SHALL be the tick on which idx wraps from 3 to 0.
REQ-013 Display register shown (16 bits) SHALL change only at a frame boundary: if pending=1, shown <= pend_data and pending <= 0; otherwise shown is held.
REQ-014 load=1 SHALL set pend_data <= data and pending <= 1; while pending=1, a further load overwrites pend_data (latest wins).
REQ-015 load=1 in the frame-boundary cycle: the boundary commits the pend_data held before that edge (if pending was 1); the new data becomes pend_data with pending=1.
REQ-016 load=1 at a frame boundary with pending=0: shown is held, new data becomes pending; it is committed one full frame (4*DIV cycles) later.
REQ-017 an SHALL equal ~(4'b0001 << idx), decoded combinationally from idx.
REQ-018 digit_val SHALL be {12'h000, shown[4*idx+3:4*idx]} unless the current digit is blanked, decoded combinationally from idx, shown and blank_lz.
REQ-019 Digit i (i=1..3) SHALL be blanked iff blank_lz=1 and shown nibbles i..3 are all zero; digit 0 is never blanked, so 16'h0000 shows a single "0".
REQ-020 blank_lz SHALL take effect combinationally, without waiting for a frame boundary.
REQ-021 The display SHALL never show a mix of old and new data nibbles within one frame (tear-free).

Reset
REQ-022 rst_n=0 SHALL immediately force cnt=0, idx=0, shown=16'h0000, pend_data=16'h0000, pending=0, with no clock edge required.
REQ-023 During reset, outputs SHALL be an=4'b1110, digit_val=16'h0000, pending=0.
REQ-024 Reset asserted mid-frame or with pending=1 SHALL discard the pending value; after deassertion counting restarts at cnt=0, idx=0.
REQ-025 load is ignored while rst_n=0; the first edge with rst_n=1 and load=1 captures data normally.

Verification (DIV=4)
REQ-026 Reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clks; digit_val=16'h0000 in every slot; pending=0.
REQ-027 load data=16'h12AF at cycle 5 -> pending=1 at the next edge; digits read 0,0,0,0 until the idx 3->0 wrap at cycle 15; then digit0=000F, digit1=000A, digit2=0002, digit3=0001; pending=0.
REQ-028 Loads 16'h1111 then 16'h2222 in the same frame -> only 2222 is ever displayed; 1111 never appears on digit_val.
REQ-029 shown=16'h00A0, blank_lz=1 -> digit0=0000, digit1=000A, digit2=FFFF, digit3=FFFF; blank_lz=0 -> digit2=digit3=0000; shown=0 with blank_lz=1 -> digit0=0000, digits 1..3 FFFF.
REQ-030 load 16'h5555 on the wrap cycle with 16'h3333 pending -> 3333 displayed for the next frame, 5555 the frame after, pending=1 between the two commits.
REQ-031 rst_n pulsed low mid-frame with pending=1 -> outputs return to an=1110, digit_val=0000, pending=0 asynchronously; the pending value is never displayed.
